// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: coefficients, offsets, mode enum and side-band payload shared by the RGB->YCbCr pipe
package ycbcr_pkg;
    // Coefficients are stored as Q0.16 magnitudes; the signs of the Cb/Cr terms are applied in stage 2.
    localparam int COEF_FRAC = 16;
    localparam int Y_R = 'h4C8B;
    localparam int Y_G = 'h9645;
    localparam int Y_B = 'h1D2F;
    localparam int CB_R = 'h2B32;
    localparam int CB_G = 'h54CD;
    localparam int C_HALF = 'h8000;
    localparam int CR_G = 'h6B2F;
    localparam int CR_B = 'h14D0;
    localparam int Y_OFS = 128;
    localparam int C_OFS = 128;

    typedef enum logic {YCC_LEVEL_SHIFT = 1'b0, YCC_STANDARD = 1'b1} ycc_mode_e;

    typedef struct packed {
        ycc_mode_e mode;
        logic      last;
    } ycc_side_t;

    // Rescale a Q0.16 coefficient to another fraction width (round-half-up when narrowing).
    function automatic longint scale_coef(input longint c, input int frac_w);
        if (frac_w >= COEF_FRAC) return c <<< (frac_w - COEF_FRAC);
        return (c + (longint'(1) <<< (COEF_FRAC - frac_w - 1))) >>> (COEF_FRAC - frac_w);
    endfunction
endpackage

// File: rtl/ycc_coef_mul.sv
// ycc_coef_mul: unsigned pixel times a constant coefficient built from shifted partial sums
module ycc_coef_mul #(
    parameter int PIX_W = 8,
    parameter int FRAC_W = 16,
    parameter logic [FRAC_W-1:0] COEF = '0
) (
    input  logic [PIX_W-1:0]        pix_i,
    output logic [PIX_W+FRAC_W-1:0] prod_o
);
    localparam int P_W = PIX_W + FRAC_W;

    // Sum one shifted copy of the pixel per set coefficient bit; constant bits prune the adders.
    always_comb begin
        prod_o = '0;
        for (int k = 0; k < FRAC_W; k++)
            prod_o = prod_o + (COEF[k] ? (P_W'(pix_i) << k) : '0);
    end
endmodule

// File: rtl/rgb_ycbcr_pipe.sv
// rgb_ycbcr_pipe: 3-stage RGB->YCbCr converter with valid/ready on both sides; YCC_ROUND_SAT_EN adds round+clamp
module rgb_ycbcr_pipe
    import ycbcr_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int FRAC_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic             in_last,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [OUT_W-1:0] y,
    output logic [OUT_W-1:0] cb,
    output logic [OUT_W-1:0] cr
);
    localparam int P_W = PIX_W + FRAC_W;
    // Product order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); index 0 sits in the LSBs.
    localparam logic [9*FRAC_W-1:0] COEFS = {
        FRAC_W'(scale_coef(CR_B, FRAC_W)), FRAC_W'(scale_coef(CR_G, FRAC_W)),
        FRAC_W'(scale_coef(C_HALF, FRAC_W)), FRAC_W'(scale_coef(C_HALF, FRAC_W)),
        FRAC_W'(scale_coef(CB_G, FRAC_W)), FRAC_W'(scale_coef(CB_R, FRAC_W)),
        FRAC_W'(scale_coef(Y_B, FRAC_W)), FRAC_W'(scale_coef(Y_G, FRAC_W)),
        FRAC_W'(scale_coef(Y_R, FRAC_W))
    };
    localparam logic signed [OUT_W-1:0] Y_OFS_F = OUT_W'(Y_OFS) <<< FRAC_W;
    localparam logic signed [OUT_W-1:0] C_OFS_F = OUT_W'(C_OFS) <<< FRAC_W;

    logic [P_W-1:0] prod [9];
    logic [P_W-1:0] prod_q [9];
    logic signed [OUT_W-1:0] ext [9];
    logic s1_valid_q, s2_valid_q, out_valid_q;
    logic s1_free, s2_free, s3_free;
    ycc_side_t s1_side_q;
    logic s2_last_q, out_last_q;
    logic signed [OUT_W-1:0] c_ofs;
    logic signed [OUT_W-1:0] y0_d, y1_d, cb0_d, cb1_d, cr0_d, cr1_d;
    logic signed [OUT_W-1:0] y0_q, y1_q, cb0_q, cb1_q, cr0_q, cr1_q;
    logic signed [OUT_W-1:0] y_d, cb_d, cr_d, y_q, cb_q, cr_q;

    // A stage may load when empty or when its content moves on this same cycle.
    assign s3_free = !out_valid_q || out_ready;
    assign s2_free = !s2_valid_q || s3_free;
    assign s1_free = !s1_valid_q || s2_free;
    assign in_ready = s1_free;

    for (genvar i = 0; i < 9; i++) begin : g_mul
        ycc_coef_mul #(
            .PIX_W(PIX_W),
            .FRAC_W(FRAC_W),
            .COEF(COEFS[i*FRAC_W +: FRAC_W])
        ) u_mul (
            .pix_i(i % 3 == 0 ? r : i % 3 == 1 ? g : b),
            .prod_o(prod[i])
        );
        assign ext[i] = signed'(OUT_W'(prod_q[i]));
    end

    // Stage 1: register the nine unsigned products with the pixel's mode/last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_side_q <= '0;
            for (int k = 0; k < 9; k++) prod_q[k] <= '0;
        end else if (s1_free) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_side_q <= '{mode: ycc_mode_e'(in_mode), last: in_last};
                for (int k = 0; k < 9; k++) prod_q[k] <= prod[k];
            end
        end
    end

    assign c_ofs = (s1_side_q.mode == YCC_STANDARD) ? C_OFS_F : '0;

    // Stage 2 next state: signed pair sums, the mode offset folded into the second term.
    always_comb begin
        y0_d = ext[0] + ext[1];
        y1_d = ext[2] - ((s1_side_q.mode == YCC_LEVEL_SHIFT) ? Y_OFS_F : '0);
        cb0_d = -ext[3] - ext[4];
        cb1_d = ext[5] + c_ofs;
        cr0_d = ext[6] - ext[7];
        cr1_d = c_ofs - ext[8];
    end

`ifdef YCC_ROUND_SAT_EN
    ycc_mode_e s2_mode_q;
`endif

    // Stage 2: register the partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_last_q <= 1'b0;
`ifdef YCC_ROUND_SAT_EN
            s2_mode_q <= YCC_LEVEL_SHIFT;
`endif
            {y0_q, y1_q, cb0_q, cb1_q, cr0_q, cr1_q} <= '0;
        end else if (s2_free) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_side_q.last;
`ifdef YCC_ROUND_SAT_EN
                s2_mode_q <= s1_side_q.mode;
`endif
                {y0_q, y1_q, cb0_q, cb1_q, cr0_q, cr1_q} <= {y0_d, y1_d, cb0_d, cb1_d, cr0_d, cr1_d};
            end
        end
    end

`ifdef YCC_ROUND_SAT_EN
    localparam logic signed [OUT_W-1:0] HALF = OUT_W'(1) <<< (FRAC_W - 1);

    // Round half up to an integer and clamp to the 8-bit range of the selected mode.
    function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [OUT_W-1:0] v, input ycc_mode_e m);
        logic signed [OUT_W-1:0] t, lo, hi;
        t = (v + HALF) >>> FRAC_W;
        lo = (m == YCC_STANDARD) ? OUT_W'(0) : OUT_W'(-128);
        hi = (m == YCC_STANDARD) ? OUT_W'(255) : OUT_W'(127);
        return (t < lo) ? lo : (t > hi) ? hi : t;
    endfunction

    // Stage 3 next state: final sums, rounded and clamped.
    always_comb begin
        y_d = rnd_sat(y0_q + y1_q, s2_mode_q);
        cb_d = rnd_sat(cb0_q + cb1_q, s2_mode_q);
        cr_d = rnd_sat(cr0_q + cr1_q, s2_mode_q);
    end
`else
    // Stage 3 next state: raw fixed-point final sums.
    always_comb begin
        y_d = y0_q + y1_q;
        cb_d = cb0_q + cb1_q;
        cr_d = cr0_q + cr1_q;
    end
`endif

    // Stage 3: output registers; they hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            {y_q, cb_q, cr_q} <= '0;
        end else if (s3_free) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_last_q <= s2_last_q;
                {y_q, cb_q, cr_q} <= {y_d, cb_d, cr_d};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last = out_last_q;
    assign y = y_q;
    assign cb = cb_q;
    assign cr = cr_q;
endmodule

// File: tb/tb_rgb_ycbcr_pipe.sv
// tb_rgb_ycbcr_pipe: directed and streaming checks of rgb_ycbcr_pipe at default parameters
module tb_rgb_ycbcr_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [31:0] y, cb, cr;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [31:0] y, cb, cr;
        logic        last;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rgb_ycbcr_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_last(in_last), .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .y(y), .cb(cb), .cr(cr)
    );

    function automatic logic [31:0] fix(input longint v, input bit m);
`ifdef YCC_ROUND_SAT_EN
        longint t;
        t = (v + 32768) >>> 16;
        if (m) t = (t < 0) ? 0 : (t > 255) ? 255 : t;
        else t = (t < -128) ? -128 : (t > 127) ? 127 : t;
        return 32'(t);
`else
        return m ? 32'(v) : 32'(v);
`endif
    endfunction

    function automatic exp_t model(input logic [7:0] rr, gg, bb, input bit m, input bit l);
        exp_t e;
        longint pr, pg, pb, yo, co;
        pr = longint'(rr);
        pg = longint'(gg);
        pb = longint'(bb);
        yo = m ? 0 : 8388608;
        co = m ? 8388608 : 0;
        e.y = fix(19595 * pr + 38469 * pg + 7471 * pb - yo, m);
        e.cb = fix(-11058 * pr - 21709 * pg + 32768 * pb + co, m);
        e.cr = fix(32768 * pr - 27439 * pg - 5328 * pb + co, m);
        e.last = l;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags out_valid=%b out_last=%b want 0 0", out_valid, out_last);
        end
        checks++;
        if ({y, cb, cr} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data y=%h cb=%h cr=%h want 0", y, cb, cr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_pixel(input string name, input logic [7:0] pr, pg, pb, input bit m,
                              input logic [31:0] ey, ecb, ecr);
        in_valid = 1'b1;
        {r, g, b} = {pr, pg, pb};
        in_mode = m;
        in_last = 1'b1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_early edge=%0d out_valid=%b want 0", name, i, out_valid);
            end
            @(posedge clk) #1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid out_valid=%b out_last=%b want 1 1", name, out_valid, out_last);
        end
        checks++;
        if ({y, cb, cr} !== {ey, ecb, ecr}) begin
            failures++;
            $display("FAIL %s_data y=%h cb=%h cr=%h want %h %h %h", name, y, cb, cr, ey, ecb, ecr);
        end
        @(posedge clk) #1;
    endtask

    task automatic run_stream(input string name, input int n, input bit rnd, input int last_idx);
        logic [7:0] pr [16], pg [16], pb [16];
        bit pm [16];
        int sent = 0, got = 0, cyc = 0;
        exp_t e, h;
        bit held = 1'b0;
        for (int i = 0; i < n; i++) begin
            pr[i] = 8'($urandom);
            pg[i] = 8'($urandom);
            pb[i] = 8'($urandom);
            pm[i] = 1'($urandom_range(0, 1));
        end
        while (got < n && cyc < 400) begin
            in_valid = (sent < n);
            if (sent < n) begin
                {r, g, b} = {pr[sent], pg[sent], pb[sent]};
                in_mode = pm[sent];
                in_last = (sent == last_idx);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || {y, cb, cr, out_last} !== h) begin
                    failures++;
                    $display("FAIL %s_hold y=%h cb=%h cr=%h last=%b want %h %h %h %b", name,
                             y, cb, cr, out_last, h.y, h.cb, h.cr, h.last);
                end
            end
            checks++;
            if (in_ready !== !((sent - got) == 3 && !out_ready)) begin
                failures++;
                $display("FAIL %s_ready in_ready=%b held=%0d out_ready=%b", name, in_ready, sent - got, out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra y=%h cb=%h cr=%h want no output", name, y, cb, cr);
                end else begin
                    e = sb.pop_front();
                    if ({y, cb, cr, out_last} !== e) begin
                        failures++;
                        $display("FAIL %s_data idx=%0d y=%h cb=%h cr=%h last=%b want %h %h %h %b", name,
                                 got, y, cb, cr, out_last, e.y, e.cb, e.cr, e.last);
                    end
                end
                got++;
            end
            held = out_valid && !out_ready;
            h = {y, cb, cr, out_last};
            if (in_valid && in_ready) begin
                sb.push_back(model(r, g, b, in_mode, in_last));
                sent++;
            end
            @(posedge clk) #1;
            cyc++;
        end
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s_count got=%0d want %0d", name, got, n);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk) #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_drain out_valid=%b want 0", name, out_valid);
            end
        end
        sb.delete();
    endtask

    task automatic test_stream();
        run_stream("stream", 16, 1'b1, 7);
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_last = 1'b1;
        {r, g, b} = {8'd200, 8'd10, 8'd30};
        repeat (3) @(posedge clk) #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_full in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || {y, cb, cr} !== 96'h0) begin
            failures++;
            $display("FAIL flush_async out_valid=%b out_last=%b y=%h cb=%h cr=%h want all 0",
                     out_valid, out_last, y, cb, cr);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        run_stream("post_reset", 8, 1'b0, 7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef YCC_ROUND_SAT_EN
        test_pixel("rs_white_m0", 8'd255, 8'd255, 8'd255, 1'b0, 32'd127, 32'd0, 32'd0);
        test_pixel("rs_red_m1", 8'd255, 8'd0, 8'd0, 1'b1, 32'd76, 32'd85, 32'd255);
`else
        test_pixel("black_m0", 8'd0, 8'd0, 8'd0, 1'b0, 32'hFF800000, 32'h0, 32'h0);
        test_pixel("black_m1", 8'd0, 8'd0, 8'd0, 1'b1, 32'h0, 32'h00800000, 32'h00800000);
        test_pixel("white_m0", 8'd255, 8'd255, 8'd255, 1'b0, 32'h007EFF01, 32'h000000FF, 32'h000000FF);
        test_pixel("red_m0", 8'd255, 8'd0, 8'd0, 1'b0, 32'hFFCC3E75, 32'hFFD4F932, 32'h007F8000);
`endif
        test_stream();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
